// File: rtl/rf80386_pkg.sv
// Shared opcode constants, sequencer state and flag layout for the branch path.
package rf80386_pkg;

    // Short Jcc opcodes 70-7F; the near 0F 8x forms reuse the low nibble.
    localparam logic [7:0] JO     = 8'h70;
    localparam logic [7:0] JNO    = 8'h71;
    localparam logic [7:0] JB     = 8'h72;
    localparam logic [7:0] JNB    = 8'h73;
    localparam logic [7:0] JE     = 8'h74;
    localparam logic [7:0] JNE    = 8'h75;
    localparam logic [7:0] JBE    = 8'h76;
    localparam logic [7:0] JNBE   = 8'h77;
    localparam logic [7:0] JS     = 8'h78;
    localparam logic [7:0] JNS    = 8'h79;
    localparam logic [7:0] JP     = 8'h7A;
    localparam logic [7:0] JNP    = 8'h7B;
    localparam logic [7:0] JL     = 8'h7C;
    localparam logic [7:0] JNL    = 8'h7D;
    localparam logic [7:0] JLE    = 8'h7E;
    localparam logic [7:0] JNLE   = 8'h7F;
    localparam logic [7:0] JMPS   = 8'hEB;
    localparam logic [7:0] LOOPNZ = 8'hE0;
    localparam logic [7:0] LOOPZ  = 8'hE1;
    localparam logic [7:0] LOOP   = 8'hE2;
    localparam logic [7:0] JCXZ   = 8'hE3;

    typedef enum logic [1:0] {IDLE, DEC, TGT, DONE} br_seq_state_t;

    // Bit order matches the flags_i port: {vf,sf,zf,pf,cf}.
    typedef struct packed {
        logic vf;
        logic sf;
        logic zf;
        logic pf;
        logic cf;
    } br_flags_t;

    // Even condition codes test the base predicate, odd codes its inverse.
    function automatic logic cond_eval(input logic [3:0] cc, input br_flags_t f);
        logic r;
        case (cc[3:1])
            3'd0:    r = f.vf;
            3'd1:    r = f.cf;
            3'd2:    r = f.zf;
            3'd3:    r = f.cf | f.zf;
            3'd4:    r = f.sf;
            3'd5:    r = f.pf;
            3'd6:    r = f.sf ^ f.vf;
            default: r = (f.sf ^ f.vf) | f.zf;
        endcase
        return r ^ cc[0];
    endfunction

endpackage

// File: rtl/br_target_adder.sv
// Branch target = eip_next + disp; 16-bit operand size wraps within IP.
module br_target_adder #(
    parameter int AWID = 32
) (
    input  logic            big,
    input  logic [AWID-1:0] eip_next,
    input  logic [AWID-1:0] disp,
    output logic [AWID-1:0] target
);
    logic [AWID-1:0] sum;

    // Wrap to 16 bits and zero-extend when not in 32-bit mode.
    always_comb begin
        sum    = eip_next + disp;
        target = big ? sum : AWID'(sum[15:0]);
    end
endmodule

// File: rtl/branch_sequencer.sv
// Sequences one relative branch (Jcc, JMPS, LOOP family, near Jcc) per request.
module branch_sequencer
    import rf80386_pkg::*;
#(
    parameter int AWID     = 32,
    parameter bit EARLY_NT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            flush_i,
    input  logic            big_i,
    input  logic            ext_i,
    input  logic [7:0]      ir_i,
    input  logic [AWID-1:0] disp_i,
    input  logic [AWID-1:0] eip_next_i,
    input  logic [AWID-1:0] ecx_i,
    input  logic [4:0]      flags_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            take_o,
    output logic            illegal_o,
    output logic            ecx_we_o,
    output logic [AWID-1:0] ecx_o,
    output logic            eip_we_o,
    output logic [AWID-1:0] eip_o
);
    br_seq_state_t   state, state_d;
    logic            big_q, ext_q;
    logic [7:0]      ir_q;
    logic [AWID-1:0] disp_q, eipn_q, ecx_q;
    br_flags_t       flags_q;

    logic            take_q, ill_q, ecx_we_q;
    logic [AWID-1:0] ecx_new_q, eip_q;

    logic            is_jcc, is_jmp, is_loopf, ill_c, take_c, we_c;
    logic            cnt_zero, dec_nz;
    logic [AWID-1:0] ecx_dec, target;

    br_target_adder #(.AWID(AWID)) u_adder (
        .big      (big_q),
        .eip_next (eipn_q),
        .disp     (disp_q),
        .target   (target)
    );

    // Opcode classification, count update and condition from latched operands.
    always_comb begin
        is_jcc   = 1'b0;
        is_jmp   = 1'b0;
        is_loopf = 1'b0;
        if (ext_q) begin
            is_jcc = (ir_q[7:4] == 4'h8);
        end else begin
            is_jcc   = (ir_q[7:4] == 4'h7);
            is_jmp   = (ir_q == JMPS);
            is_loopf = (ir_q[7:2] == LOOPNZ[7:2]);
        end
        ill_c    = !(is_jcc || is_jmp || is_loopf);
        cnt_zero = big_q ? (ecx_q == '0) : (ecx_q[15:0] == 16'h0);
        ecx_dec  = big_q ? (ecx_q - AWID'(1))
                         : {ecx_q[AWID-1:16], ecx_q[15:0] - 16'd1};
        dec_nz   = big_q ? (ecx_dec != '0) : (ecx_dec[15:0] != 16'h0);
        take_c   = 1'b0;
        if (is_jcc) begin
            take_c = cond_eval(ir_q[3:0], flags_q);
        end else if (is_jmp) begin
            take_c = 1'b1;
        end else if (is_loopf) begin
            case (ir_q[1:0])
                2'd0:    take_c = dec_nz && !flags_q.zf;
                2'd1:    take_c = dec_nz &&  flags_q.zf;
                2'd2:    take_c = dec_nz;
                default: take_c = cnt_zero;
            endcase
        end
        // JCXZ only reads the count; LOOP/LOOPZ/LOOPNZ always write it back.
        we_c = is_loopf && (ir_q[1:0] != 2'd3);
    end

    // Next-state: flush aborts before commit; DONE always completes.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (req_i && !flush_i) state_d = DEC;
            DEC: begin
                if (flush_i)                              state_d = IDLE;
                else if (EARLY_NT && !is_loopf && !take_c) state_d = DONE;
                else                                       state_d = TGT;
            end
            TGT:  state_d = flush_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register, operand latch at accept and result capture in DEC/TGT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            big_q     <= 1'b0;
            ext_q     <= 1'b0;
            ir_q      <= '0;
            disp_q    <= '0;
            eipn_q    <= '0;
            ecx_q     <= '0;
            flags_q   <= '0;
            take_q    <= 1'b0;
            ill_q     <= 1'b0;
            ecx_we_q  <= 1'b0;
            ecx_new_q <= '0;
            eip_q     <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && req_i && !flush_i) begin
                big_q   <= big_i;
                ext_q   <= ext_i;
                ir_q    <= ir_i;
                disp_q  <= disp_i;
                eipn_q  <= eip_next_i;
                ecx_q   <= ecx_i;
                flags_q <= flags_i;
                eip_q   <= '0;
            end
            if (state == DEC) begin
                take_q    <= take_c;
                ill_q     <= ill_c;
                ecx_we_q  <= we_c;
                ecx_new_q <= ecx_dec;
            end
            if (state == TGT) eip_q <= target;
        end
    end

    // Commit outputs exist only in the DONE cycle.
    always_comb begin
        busy_o    = (state != IDLE);
        done_o    = (state == DONE);
        take_o    = done_o && take_q;
        illegal_o = done_o && ill_q;
        ecx_we_o  = done_o && ecx_we_q;
        eip_we_o  = done_o && take_q;
        ecx_o     = done_o ? ecx_new_q : '0;
        eip_o     = done_o ? eip_q : '0;
    end
endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: directed vectors, decoupled monitor.
module tb_branch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, flush = 1'b0, big = 1'b0, ext = 1'b0;
    logic [7:0]  ir = '0;
    logic [31:0] disp = '0, eipn = '0, ecx = '0;
    logic [4:0]  flags = '0;
    logic        busy, done, take, ill, ecx_we, eip_we;
    logic [31:0] ecx_o, eip_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        take;
        logic        ill;
        logic        ecx_we;
        logic [31:0] ecx;
        logic        eip_we;
        logic [31:0] eip;
        int          lat;
        int          t0;
    } exp_t;
    exp_t sb[$];

    branch_sequencer #(.AWID(32), .EARLY_NT(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .flush_i(flush), .big_i(big),
        .ext_i(ext), .ir_i(ir), .disp_i(disp), .eip_next_i(eipn), .ecx_i(ecx),
        .flags_i(flags), .busy_o(busy), .done_o(done), .take_o(take),
        .illegal_o(ill), .ecx_we_o(ecx_we), .ecx_o(ecx_o), .eip_we_o(eip_we),
        .eip_o(eip_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop an expectation on every done pulse, police strobes otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("take", 32'(take), 32'(e.take));
                    check("illegal", 32'(ill), 32'(e.ill));
                    check("ecx_we", 32'(ecx_we), 32'(e.ecx_we));
                    check("eip_we", 32'(eip_we), 32'(e.eip_we));
                    if (e.ecx_we) check("ecx_o", ecx_o, e.ecx);
                    if (e.eip_we) check("eip_o", eip_o, e.eip);
                    if (e.lat >= 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end else if (ecx_we || eip_we || ill || take) begin
                check("strobe_outside_done", {28'd0, ecx_we, eip_we, ill, take}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Drive one request, queue its expectation, then scramble inputs.
    task automatic issue(input logic b, input logic x, input logic [7:0] op,
                         input logic [31:0] d, input logic [31:0] en,
                         input logic [31:0] c, input logic [4:0] f,
                         input logic et, input logic ei, input logic ew,
                         input logic [31:0] ec, input logic ejw,
                         input logic [31:0] ej, input int lat);
        exp_t e;
        @(negedge clk);
        big = b; ext = x; ir = op; disp = d; eipn = en; ecx = c; flags = f;
        req = 1'b1;
        e.take = et; e.ill = ei; e.ecx_we = ew; e.ecx = ec;
        e.eip_we = ejw; e.eip = ej; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        ecx = $urandom; flags = 5'($urandom); disp = $urandom;
        eipn = $urandom; ir = 8'($urandom); big = 1'($urandom); ext = 1'($urandom);
        wait_idle();
    endtask

    // Start a request without an expectation and walk it into TGT.
    task automatic start_to_tgt(input logic [7:0] op, input logic b);
        @(negedge clk);
        big = b; ext = 1'b0; ir = op; ecx = 32'h5; flags = 5'b00100;
        disp = 32'h4; eipn = 32'h100; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, take, ill, ecx_we, eip_we}, 32'd0);
        check("reset_ecx_eip", ecx_o | eip_o, 32'd0);
        rst = 1'b0;

        // LOOP 16-bit, count 1 -> 0, not taken, high half preserved
        issue(0, 0, 8'hE2, 32'hFFFF_FFFC, 32'h0000_0100, 32'h1234_0001, 5'b00000,
              0, 0, 1, 32'h1234_0000, 0, 32'h0, 3);
        // LOOP 32-bit, count 0 wraps to all-ones, taken
        issue(1, 0, 8'hE2, 32'h0000_0010, 32'h8000_0000, 32'h0, 5'b00000,
              1, 0, 1, 32'hFFFF_FFFF, 1, 32'h8000_0010, 3);
        // LOOP 16-bit, CX 0 wraps to FFFF with upper half intact, IP wrap
        issue(0, 0, 8'hE2, 32'hFFFF_FFE0, 32'h0000_0010, 32'hABCD_0000, 5'b00000,
              1, 0, 1, 32'hABCD_FFFF, 1, 32'h0000_FFF0, 3);
        // JE taken with IP wrap
        issue(0, 0, 8'h74, 32'h0000_0020, 32'h0000_FFF0, 32'h0, 5'b00100,
              1, 0, 0, 32'h0, 1, 32'h0000_0010, 3);
        // JE not taken finishes early
        issue(0, 0, 8'h74, 32'h0000_0020, 32'h0000_FFF0, 32'h0, 5'b00000,
              0, 0, 0, 32'h0, 0, 32'h0, 2);
        // JCXZ: CX zero in 16-bit mode, ECX nonzero in 32-bit mode
        issue(0, 0, 8'hE3, 32'h0000_0008, 32'h0000_0200, 32'h0001_0000, 5'b00000,
              1, 0, 0, 32'h0, 1, 32'h0000_0208, 3);
        issue(1, 0, 8'hE3, 32'h0000_0008, 32'h0000_0200, 32'h0001_0000, 5'b00000,
              0, 0, 0, 32'h0, 0, 32'h0, -1);
        // LOOPNZ with zf=0, count 2 -> 1, taken
        issue(0, 0, 8'hE0, 32'hFFFF_FFF0, 32'h0000_0300, 32'h0000_0002, 5'b00000,
              1, 0, 1, 32'h0000_0001, 1, 32'h0000_02F0, 3);
        // LOOPZ with zf=0 decrements but does not branch
        issue(1, 0, 8'hE1, 32'h0000_0040, 32'h0000_0300, 32'h0000_0009, 5'b00000,
              0, 0, 1, 32'h0000_0008, 0, 32'h0, 3);
        // Near JNE 32-bit
        issue(1, 1, 8'h85, 32'h0000_0100, 32'h1000_0000, 32'h0, 5'b00000,
              1, 0, 0, 32'h0, 1, 32'h1000_0100, 3);
        // JL with vf=1, sf=0
        issue(1, 0, 8'h7C, 32'h0000_0004, 32'h0000_0400, 32'h0, 5'b10000,
              1, 0, 0, 32'h0, 1, 32'h0000_0404, 3);

        // Flush in TGT: nothing commits, sequencer idles
        start_to_tgt(8'hE1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", 32'(busy), 32'd0);
        issue(1, 0, 8'hEB, 32'hFFFF_FF00, 32'h0000_1000, 32'h0, 5'b00000,
              1, 0, 0, 32'h0, 1, 32'h0000_0F00, 3);

        // Illegal near form
        issue(0, 1, 8'h9F, 32'h0000_0004, 32'h0000_0100, 32'h0, 5'b11111,
              0, 1, 0, 32'h0, 0, 32'h0, -1);

        // Reset while in TGT clears outputs immediately
        start_to_tgt(8'hE2, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_flags", {busy, done, take, ill, ecx_we, eip_we}, 32'd0);
        check("rst_mid_data", ecx_o | eip_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
